// File: rtl/debug_disp_pkg.sv
// ---------------------------------------------------------------------------
// debug_disp_pkg
// Shared types and constants for the debug display path.
//   dispState_t : arbiter state (IDLE = display blank, SHOW = one owner lit)
//   SEG_TABLE   : hex digit -> {a,b,c,d,e,f,g} segment pattern, active-high
//   GNDS_OFF    : all digit grounds released (display dark)
//   GNDS_FIRST  : digit 0 grounded, the first digit of every frame
// ---------------------------------------------------------------------------
package debug_disp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } dispState_t;

  localparam logic [3:0] GNDS_OFF   = 4'b1111;
  localparam logic [3:0] GNDS_FIRST = 4'b1110;

  // Packed so it can be indexed by a 4-bit nibble; entry 15 is leftmost.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h47,  // F
    7'h4F,  // E
    7'h3D,  // d
    7'h4E,  // C
    7'h1F,  // b
    7'h77,  // A
    7'h7B,  // 9
    7'h7F,  // 8
    7'h70,  // 7
    7'h5F,  // 6
    7'h5B,  // 5
    7'h33,  // 4
    7'h79,  // 3
    7'h6D,  // 2
    7'h30,  // 1
    7'h7E   // 0
  };

endpackage

// File: rtl/hex_to_7seg.sv
// ---------------------------------------------------------------------------
// hex_to_7seg
// Purely combinational hex digit to seven-segment decoder, shared with other
// debug outputs on the board.
//   i_nibble : 4-bit hex digit
//   o_seg    : segments {a,b,c,d,e,f,g}, active-high
// ---------------------------------------------------------------------------
module hex_to_7seg
  import debug_disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/debug_display_arbiter.sv
// ---------------------------------------------------------------------------
// debug_display_arbiter
// Shares the single 4-digit multiplexed 7-segment debug display between
// N_SRC debug requesters. Ownership is granted round-robin and held for at
// least HOLD_CYCLES; the owner's 16-bit word is latched once per scan frame
// so the four digits always come from the same sample.
//
// Ports
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   req        : per-source display request, level-sensitive
//   src_data   : source k word at bits [16k+15:16k]
//   freeze     : stalls the hold counter (current owner kept, scan runs)
//   grant      : one-hot current owner, zero when idle (registered)
//   active_src : index of current / last owner (registered)
//   gnds       : digit grounds, active-low one-hot (registered)
//   display    : segments {a..g}, decode of the registered digit nibble
// ---------------------------------------------------------------------------
module debug_display_arbiter
  import debug_disp_pkg::*;
#(
  parameter int N_SRC       = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int HOLD_CYCLES = 50_000_000
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC-1:0]         req,
  input  logic [16*N_SRC-1:0]      src_data,
  input  logic                     freeze,
  output logic [N_SRC-1:0]         grant,
  output logic [$clog2(N_SRC)-1:0] active_src,
  output logic [3:0]               gnds,
  output logic [6:0]               display
);

  localparam int AW = $clog2(N_SRC);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int SW = $clog2(SCAN_DIV);

  localparam logic [AW-1:0] LAST_SRC  = AW'(N_SRC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  dispState_t       r_state;
  dispState_t       w_nextState;

  logic [N_SRC-1:0] r_grant;
  logic [AW-1:0]    r_activeSrc;
  logic [HW-1:0]    r_holdCnt;
  logic [SW-1:0]    r_scanCnt;
  logic [1:0]       r_digitIdx;
  logic [3:0]       r_gnds;
  logic [15:0]      r_frame;
  logic             r_ownerDrop;

  logic [N_SRC-1:0] w_reqMasked;
  logic [AW-1:0]    w_winner;
  logic             w_found;
  logic             w_expire;
  logic             w_arbitrate;
  logic             w_switch;
  logic             w_regrant;
  logic             w_goIdle;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg;

  // Round-robin search. It starts one past the current owner and wraps back
  // to the owner itself, so a sole requester can be re-granted. When the
  // search was triggered by the owner dropping its request, the owner is
  // masked out so it cannot win on a request that re-appears in that cycle.
  always_comb begin
    logic [AW-1:0] idx;
    w_reqMasked = req;
    w_found     = 1'b0;
    w_winner    = r_activeSrc;
    idx         = '0;
    if (r_ownerDrop) begin
      w_reqMasked[r_activeSrc] = 1'b0;
    end
    for (int i = 1; i <= N_SRC; i++) begin
      idx = AW'((int'(r_activeSrc) + i) % N_SRC);
      if (!w_found && w_reqMasked[idx]) begin
        w_found  = 1'b1;
        w_winner = idx;
      end
    end
  end

  // Next-state logic. Arbitration runs every cycle while idle, and while
  // showing only at hold expiry or one cycle after the owner dropped req.
  // A single arbitration covers a simultaneous expiry and drop: the owner's
  // low request simply loses the search.
  always_comb begin
    w_nextState = r_state;
    w_switch    = 1'b0;
    w_regrant   = 1'b0;
    w_goIdle    = 1'b0;
    w_expire    = (r_state == SHOW) && !freeze && (r_holdCnt == HOLD_LAST);
    w_arbitrate = (r_state == IDLE) || w_expire ||
                  ((r_state == SHOW) && r_ownerDrop);
    if (w_arbitrate) begin
      if (w_found) begin
        w_nextState = SHOW;
        if ((r_state == IDLE) || (w_winner != r_activeSrc)) begin
          w_switch = 1'b1;
        end else begin
          w_regrant = 1'b1;
        end
      end else begin
        w_nextState = IDLE;
        w_goIdle    = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Datapath: grant, hold counter, scan counter, digit rotation, frame latch.
  // A new owner restarts the frame at digit 0 with its word loaded at once.
  // Re-granting the same owner only reloads the hold counter so the scan and
  // the frame already on the display are not disturbed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant     <= '0;
      r_activeSrc <= LAST_SRC;
      r_holdCnt   <= '0;
      r_scanCnt   <= '0;
      r_digitIdx  <= 2'd0;
      r_gnds      <= GNDS_OFF;
      r_frame     <= 16'h0000;
      r_ownerDrop <= 1'b0;
    end else begin
      r_ownerDrop <= (r_state == SHOW) && !w_arbitrate && !req[r_activeSrc];
      if (w_switch) begin
        r_grant     <= N_SRC'(1) << w_winner;
        r_activeSrc <= w_winner;
        r_holdCnt   <= '0;
        r_scanCnt   <= '0;
        r_digitIdx  <= 2'd0;
        r_gnds      <= GNDS_FIRST;
        r_frame     <= src_data[{w_winner, 4'h0} +: 16];
      end else if (w_goIdle) begin
        r_grant    <= '0;
        r_holdCnt  <= '0;
        r_scanCnt  <= '0;
        r_digitIdx <= 2'd0;
        r_gnds     <= GNDS_OFF;
      end else if (r_state == SHOW) begin
        if (w_regrant) begin
          r_holdCnt <= '0;
        end else if (!freeze) begin
          r_holdCnt <= r_holdCnt + 1'b1;
        end
        if (r_scanCnt == SCAN_LAST) begin
          r_scanCnt  <= '0;
          r_digitIdx <= r_digitIdx + 2'd1;
          r_gnds     <= {r_gnds[2:0], r_gnds[3]};
          if (r_digitIdx == 2'd3) begin
            r_frame <= src_data[{r_activeSrc, 4'h0} +: 16];
          end
        end else begin
          r_scanCnt <= r_scanCnt + 1'b1;
        end
      end
    end
  end

  // The lit digit's nibble comes straight from registers, so display moves
  // in the same cycle as gnds. Blanked while idle.
  assign w_nibble = r_frame[{r_digitIdx, 2'b00} +: 4];

  hex_to_7seg u_hexToSeg (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  assign grant      = r_grant;
  assign active_src = r_activeSrc;
  assign gnds       = r_gnds;
  assign display    = (r_state == SHOW) ? w_seg : 7'h00;

endmodule

// File: tb/tb_debug_display_arbiter.sv
// ---------------------------------------------------------------------------
// tb_debug_display_arbiter
// Directed scoreboard bench. Each stimulus step pushes the hand-derived
// display state expected in specific future cycles; a negedge monitor pops
// and compares them as the cycles arrive.
// ---------------------------------------------------------------------------
module tb_debug_display_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] srcData;
  logic        freeze;
  logic [3:0]  grant;
  logic [1:0]  activeSrc;
  logic [3:0]  gnds;
  logic [6:0]  display;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int          cyc;
    logic [3:0]  grant;
    logic [3:0]  gnds;
    logic [6:0]  disp;
    logic [1:0]  act;
    logic [95:0] tag;
  } exp_t;

  exp_t sbQ[$];

  logic [3:0] gTbl [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  debug_display_arbiter #(
    .N_SRC       (4),
    .SCAN_DIV    (4),
    .HOLD_CYCLES (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .src_data   (srcData),
    .freeze     (freeze),
    .grant      (grant),
    .active_src (activeSrc),
    .gnds       (gnds),
    .display    (display)
  );

  // 10-unit clock; cyc counts rising edges.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Digit ground pattern k cycles after an owner takes the display.
  function automatic logic [3:0] gndsFor(input int k);
    return gTbl[(k / 4) % 4];
  endfunction

  task automatic pushExp(input int c, input logic [3:0] g, input logic [3:0] gn,
                         input logic [6:0] d, input logic [1:0] a,
                         input logic [95:0] t);
    exp_t e;
    e.cyc = c; e.grant = g; e.gnds = gn; e.disp = d; e.act = a; e.tag = t;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input logic [95:0] tag, input int c,
                             input logic [3:0] g, input logic [3:0] gn,
                             input logic [6:0] d, input logic [1:0] a);
    checks++;
    if (grant !== g || gnds !== gn || display !== d || activeSrc !== a) begin
      errors++;
      $display("[TB] FAIL %0s cyc=%0d: got grant=%b gnds=%b display=%h active=%0d, want grant=%b gnds=%b display=%h active=%0d",
               tag, c, grant, gnds, display, activeSrc, g, gn, d, a);
    end
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int target, input logic [3:0] r,
                               input logic [63:0] d, input logic f);
    waitCycle(target);
    req     = r;
    srcData = d;
    freeze  = f;
  endtask

  // Scoreboard monitor: compares every expectation whose cycle has arrived.
  always @(negedge clk) begin
    while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
      exp_t e;
      e = sbQ.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL stale %0s: expectation for cyc=%0d seen at cyc=%0d", e.tag, e.cyc, cyc);
      end else begin
        checkOutput(e.tag, e.cyc, e.grant, e.gnds, e.disp, e.act);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, queue=%0d", sbQ.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] rrData;
    logic [3:0]  ownG [4];
    logic [6:0]  ownD [4];
    logic [1:0]  ownA [4];
    logic [6:0]  t2Disp [5];
    int          o;
    int          guard;

    rrData = 64'h8888_5555_2222_1111;
    ownG   = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    ownD   = '{7'h30, 7'h6D, 7'h7F, 7'h30};
    ownA   = '{2'd0, 2'd1, 2'd3, 2'd0};
    t2Disp = '{7'h47, 7'h79, 7'h77, 7'h30, 7'h47};

    rst = 1'b1; req = 4'b0000; srcData = 64'h0; freeze = 1'b0;
    waitCycle(3);
    checkOutput("reset", cyc, 4'b0000, 4'b1111, 7'h00, 2'd3);
    rst = 1'b0;

    // Idle with no requests; async pulse between edges while idle.
    for (int c = 4; c <= 103; c++) pushExp(c, 4'b0000, 4'b1111, 7'h00, 2'd3, "idle");
    waitCycle(60);
    #1 rst = 1'b1;
    #1 checkOutput("idleRst", cyc, 4'b0000, 4'b1111, 7'h00, 2'd3);
    rst = 1'b0;

    // Single source 1A3F: F, 3, A, 1 then the frame wraps back to F.
    for (int k = 0; k < 20; k++)
      pushExp(105 + k, 4'b0001, gndsFor(k), t2Disp[k / 4], 2'd0, "scan1A3F");
    applyStimulus(104, 4'b0001, 64'h1A3F, 1'b0);

    // Async reset mid-frame clears outputs without a clock edge.
    waitCycle(125);
    #1 rst = 1'b1;
    #1 checkOutput("asyncRst", cyc, 4'b0000, 4'b1111, 7'h00, 2'd3);
    req = 4'b0000;
    #1 rst = 1'b0;

    // Round robin over 1011: owners 0,1,3,0 for 32 cycles each, no gaps.
    for (int k = 0; k < 128; k++) begin
      o = k / 32;
      pushExp(127 + k, ownG[o], gndsFor(k % 32), ownD[o], ownA[o], "rrHold");
    end
    // Owner 1 drops req at hold cycle 10, owner 3 wins two cycles later.
    for (int k = 0; k < 12; k++)
      pushExp(255 + k, 4'b0010, gndsFor(k), 7'h6D, 2'd1, "dropOld");
    for (int k = 0; k < 5; k++)
      pushExp(267 + k, 4'b1000, gndsFor(k), 7'h7F, 2'd3, "dropNew");
    for (int c = 272; c <= 276; c++) pushExp(c, 4'b0000, 4'b1111, 7'h00, 2'd3, "dropIdle");
    applyStimulus(126, 4'b1011, rrData, 1'b0);
    applyStimulus(265, 4'b1001, rrData, 1'b0);
    applyStimulus(270, 4'b0000, rrData, 1'b0);

    // Freeze for 100 cycles while owner 1 is at hold count 4.
    for (int k = 0; k < 32; k++)
      pushExp(278 + k, 4'b0001, gndsFor(k), 7'h30, 2'd0, "frzPre");
    for (int k = 0; k < 132; k++)
      pushExp(310 + k, 4'b0010, gndsFor(k), 7'h6D, 2'd1, "frzHold");
    for (int k = 0; k < 5; k++)
      pushExp(442 + k, 4'b0001, gndsFor(k), 7'h30, 2'd0, "frzNext");
    for (int c = 447; c <= 449; c++) pushExp(c, 4'b0000, 4'b1111, 7'h00, 2'd0, "frzIdle");
    applyStimulus(277, 4'b0011, rrData, 1'b0);
    applyStimulus(314, 4'b0011, rrData, 1'b1);
    applyStimulus(414, 4'b0011, rrData, 1'b0);
    applyStimulus(445, 4'b0000, rrData, 1'b0);

    // Word changes 0000 -> FFFF mid-frame; visible only after the wrap.
    for (int k = 0; k < 24; k++)
      pushExp(451 + k, 4'b0001, gndsFor(k), (k < 16) ? 7'h7E : 7'h47, 2'd0, "tearFree");
    applyStimulus(450, 4'b0001, 64'h0000, 1'b0);
    applyStimulus(452, 4'b0001, 64'hFFFF, 1'b0);
    applyStimulus(474, 4'b0000, 64'hFFFF, 1'b0);

    guard = 0;
    while (sbQ.size() > 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    #1;
    if (sbQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", sbQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
